// File: rtl/flow_queue_allocator.sv
// flow_queue_allocator
// Maps arriving packet fragments onto reassembly queues by flow id. Each queue
// remembers its flow, how many fragments it holds, whether the last fragment
// has arrived, and how long it has been idle. Idle incomplete queues are
// reclaimed after TIMEOUT cycles. All results appear one cycle after the strobe.

module flow_queue_allocator #(
  parameter int FLOWID_W = 14,
  parameter int FRAG_W   = 4,
  parameter int QNUM     = 32,
  parameter int QID_W    = 5,
  parameter int AGE_W    = 16,
  parameter int TIMEOUT  = 50000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [FLOWID_W-1:0] iv_flowid,
  input  logic [FRAG_W-1:0]   iv_frag_id,
  input  logic                i_last_frag_flag,
  input  logic                i_flowid_wr,
  output logic [QID_W-1:0]    ov_queue_id,
  output logic [FRAG_W:0]     ov_queue_usedw,
  output logic                o_queue_id_wr,
  output logic                o_last_frag,
  output logic                o_all_queue_used,
  output logic                o_frag_err,
  input  logic [QID_W-1:0]    iv_queue_id_free,
  input  logic                i_queue_id_free_wr,
  output logic [QNUM-1:0]     ov_queue_empty,
  output logic [QNUM-1:0]     ov_timeout_vec
);

  // An entry is reclaimed on the edge where its age would reach TIMEOUT.
  localparam logic [AGE_W-1:0]  AGE_LAST  = AGE_W'(TIMEOUT - 1);
  localparam logic [FRAG_W:0]   USEDW_ONE = (FRAG_W + 1)'(1'b1);

  // Queue table
  logic [QNUM-1:0]     valid_r;
  logic [QNUM-1:0]     complete_r;
  logic [FLOWID_W-1:0] flowid_r [QNUM];
  logic [FRAG_W:0]     usedw_r  [QNUM];
  logic [AGE_W-1:0]    age_r    [QNUM];

  // Per-cycle decisions
  logic [QNUM-1:0]  free_sel_s;
  logic [QNUM-1:0]  match_s;
  logic [QNUM-1:0]  empty_s;
  logic [QNUM-1:0]  timeout_s;
  logic [QID_W-1:0] hit_q_s;
  logic [QID_W-1:0] alloc_q_s;
  logic             hit_s;
  logic             any_empty_s;
  logic             frag_zero_s;
  logic             frag_ok_s;
  logic [FRAG_W:0]  hit_usedw_s;
  logic [FRAG_W:0]  next_usedw_s;
  logic             accept_hit_s;
  logic             alloc_s;
  logic             full_s;
  logic             err_s;

  // Decode the release strobe into a one-hot queue mask.
  always_comb begin
    free_sel_s = {QNUM{1'b0}};
    if (i_queue_id_free_wr) begin
      free_sel_s[iv_queue_id_free] = 1'b1;
    end else begin
      free_sel_s = {QNUM{1'b0}};
    end
  end

  // Parallel flow-id compare; a queue being released is invisible to lookup and allocation.
  always_comb begin
    match_s = {QNUM{1'b0}};
    empty_s = {QNUM{1'b0}};
    for (int q = 0; q < QNUM; q++) begin
      match_s[q] = valid_r[q] & (flowid_r[q] == iv_flowid) & ~free_sel_s[q];
      empty_s[q] = ~valid_r[q] & ~free_sel_s[q];
    end
  end

  // Lowest-index priority encoders for the matching queue and the free queue.
  always_comb begin
    hit_q_s   = {QID_W{1'b0}};
    alloc_q_s = {QID_W{1'b0}};
    for (int q = QNUM - 1; q >= 0; q--) begin
      hit_q_s   = match_s[q] ? QID_W'(q) : hit_q_s;
      alloc_q_s = empty_s[q] ? QID_W'(q) : alloc_q_s;
    end
    hit_s       = |match_s;
    any_empty_s = |empty_s;
  end

  // Classify the arriving fragment into exactly one outcome.
  always_comb begin
    frag_zero_s  = (iv_frag_id == {FRAG_W{1'b0}});
    hit_usedw_s  = usedw_r[hit_q_s];
    next_usedw_s = hit_usedw_s + USEDW_ONE;
    // A full queue (usedw = 2^FRAG_W) can never match a FRAG_W-bit index, so usedw cannot wrap.
    frag_ok_s    = ~complete_r[hit_q_s] & (hit_usedw_s == {1'b0, iv_frag_id});
    accept_hit_s = i_flowid_wr & hit_s & frag_ok_s;
    alloc_s      = i_flowid_wr & ~hit_s & frag_zero_s & any_empty_s;
    full_s       = i_flowid_wr & ~hit_s & frag_zero_s & ~any_empty_s;
    err_s        = i_flowid_wr & ((hit_s & ~frag_ok_s) | (~hit_s & ~frag_zero_s));
  end

  // Aging expiry; an accepted fragment or a release on the same queue suppresses it.
  always_comb begin
    timeout_s = {QNUM{1'b0}};
    for (int q = 0; q < QNUM; q++) begin
      timeout_s[q] = valid_r[q] & ~complete_r[q] & (age_r[q] == AGE_LAST) & ~free_sel_s[q]
                     & ~(accept_hit_s & (hit_q_s == QID_W'(q)));
    end
  end

  // Table update: clear on reset/release/expiry, else accept, allocate or age.
  always_ff @(posedge i_clk) begin
    for (int q = 0; q < QNUM; q++) begin
      if (i_rst || free_sel_s[q] || timeout_s[q]) begin
        valid_r[q]    <= 1'b0;
        complete_r[q] <= 1'b0;
        flowid_r[q]   <= {FLOWID_W{1'b0}};
        usedw_r[q]    <= {(FRAG_W + 1){1'b0}};
        age_r[q]      <= {AGE_W{1'b0}};
      end else if (accept_hit_s && (hit_q_s == QID_W'(q))) begin
        usedw_r[q]    <= next_usedw_s;
        complete_r[q] <= i_last_frag_flag;
        age_r[q]      <= {AGE_W{1'b0}};
      end else if (alloc_s && (alloc_q_s == QID_W'(q))) begin
        valid_r[q]    <= 1'b1;
        complete_r[q] <= i_last_frag_flag;
        flowid_r[q]   <= iv_flowid;
        usedw_r[q]    <= USEDW_ONE;
        age_r[q]      <= {AGE_W{1'b0}};
      end else if (valid_r[q] && !complete_r[q] && (age_r[q] != {AGE_W{1'b1}})) begin
        age_r[q]      <= age_r[q] + AGE_W'(1'b1);
      end else begin
        age_r[q]      <= age_r[q];
      end
    end
  end

  // Registered result strobes and the queue/usedw they qualify.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_queue_id_wr    <= 1'b0;
      o_last_frag      <= 1'b0;
      o_all_queue_used <= 1'b0;
      o_frag_err       <= 1'b0;
      ov_queue_id      <= {QID_W{1'b0}};
      ov_queue_usedw   <= {(FRAG_W + 1){1'b0}};
      ov_timeout_vec   <= {QNUM{1'b0}};
    end else begin
      o_queue_id_wr    <= accept_hit_s | alloc_s;
      o_last_frag      <= (accept_hit_s | alloc_s) & i_last_frag_flag;
      o_all_queue_used <= full_s;
      o_frag_err       <= err_s;
      ov_timeout_vec   <= timeout_s;
      if (accept_hit_s) begin
        ov_queue_id    <= hit_q_s;
        ov_queue_usedw <= next_usedw_s;
      end else if (alloc_s) begin
        ov_queue_id    <= alloc_q_s;
        ov_queue_usedw <= USEDW_ONE;
      end else begin
        ov_queue_id    <= {QID_W{1'b0}};
        ov_queue_usedw <= {(FRAG_W + 1){1'b0}};
      end
    end
  end

  assign ov_queue_empty = ~valid_r;

  flow_queue_allocator_chk #(
    .FRAG_W (FRAG_W),
    .QNUM   (QNUM)
  ) u_chk (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_flowid_wr      (i_flowid_wr),
    .o_queue_id_wr    (o_queue_id_wr),
    .o_last_frag      (o_last_frag),
    .o_all_queue_used (o_all_queue_used),
    .o_frag_err       (o_frag_err),
    .ov_queue_usedw   (ov_queue_usedw),
    .ov_queue_empty   (ov_queue_empty),
    .ov_timeout_vec   (ov_timeout_vec)
  );

endmodule

// Interface invariants of the allocator, kept apart from the datapath.
module flow_queue_allocator_chk #(
  parameter int FRAG_W = 4,
  parameter int QNUM   = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_flowid_wr,
  input logic              o_queue_id_wr,
  input logic              o_last_frag,
  input logic              o_all_queue_used,
  input logic              o_frag_err,
  input logic [FRAG_W:0]   ov_queue_usedw,
  input logic [QNUM-1:0]   ov_queue_empty,
  input logic [QNUM-1:0]   ov_timeout_vec
);

  a_one_result: assert property (@(posedge i_clk) disable iff (i_rst)
    i_flowid_wr |=> $onehot({o_queue_id_wr, o_all_queue_used, o_frag_err}));

  a_no_spurious: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0({o_queue_id_wr, o_all_queue_used, o_frag_err}));

  a_last_qualified: assert property (@(posedge i_clk) disable iff (i_rst)
    o_last_frag |-> o_queue_id_wr);

  a_usedw_nonzero: assert property (@(posedge i_clk) disable iff (i_rst)
    o_queue_id_wr |-> (ov_queue_usedw != {(FRAG_W + 1){1'b0}}));

  a_timeout_empties: assert property (@(posedge i_clk) disable iff (i_rst)
    (ov_timeout_vec & ~ov_queue_empty) == {QNUM{1'b0}});

  a_reset_state: assert property (@(posedge i_clk)
    i_rst |=> (ov_queue_empty == {QNUM{1'b1}}) && !o_queue_id_wr && !o_frag_err && !o_all_queue_used);

endmodule

// File: tb/tb_flow_queue_allocator.sv
// Directed bench for flow_queue_allocator with hand-computed expectations.
// Uses TIMEOUT=16 so aging can be exercised in a short run.

module tb_flow_queue_allocator;

  localparam int FLOWID_W = 14;
  localparam int FRAG_W   = 4;
  localparam int QNUM     = 32;
  localparam int QID_W    = 5;
  localparam int AGE_W    = 16;
  localparam int TIMEOUT  = 16;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [FLOWID_W-1:0] iv_flowid;
  logic [FRAG_W-1:0]   iv_frag_id;
  logic                i_last_frag_flag;
  logic                i_flowid_wr;
  logic [QID_W-1:0]    ov_queue_id;
  logic [FRAG_W:0]     ov_queue_usedw;
  logic                o_queue_id_wr;
  logic                o_last_frag;
  logic                o_all_queue_used;
  logic                o_frag_err;
  logic [QID_W-1:0]    iv_queue_id_free;
  logic                i_queue_id_free_wr;
  logic [QNUM-1:0]     ov_queue_empty;
  logic [QNUM-1:0]     ov_timeout_vec;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  flow_queue_allocator #(
    .FLOWID_W (FLOWID_W),
    .FRAG_W   (FRAG_W),
    .QNUM     (QNUM),
    .QID_W    (QID_W),
    .AGE_W    (AGE_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .iv_flowid          (iv_flowid),
    .iv_frag_id         (iv_frag_id),
    .i_last_frag_flag   (i_last_frag_flag),
    .i_flowid_wr        (i_flowid_wr),
    .ov_queue_id        (ov_queue_id),
    .ov_queue_usedw     (ov_queue_usedw),
    .o_queue_id_wr      (o_queue_id_wr),
    .o_last_frag        (o_last_frag),
    .o_all_queue_used   (o_all_queue_used),
    .o_frag_err         (o_frag_err),
    .iv_queue_id_free   (iv_queue_id_free),
    .i_queue_id_free_wr (i_queue_id_free_wr),
    .ov_queue_empty     (ov_queue_empty),
    .ov_timeout_vec     (ov_timeout_vec)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [FLOWID_W-1:0] fid, input logic [FRAG_W-1:0] frag, input logic last);
    iv_flowid        = fid;
    iv_frag_id       = frag;
    i_last_frag_flag = last;
    i_flowid_wr      = 1'b1;
    cycle();
    i_flowid_wr      = 1'b0;
    i_last_frag_flag = 1'b0;
  endtask

  task automatic do_free(input logic [QID_W-1:0] q);
    iv_queue_id_free   = q;
    i_queue_id_free_wr = 1'b1;
    cycle();
    i_queue_id_free_wr = 1'b0;
  endtask

  task automatic expect_ok(input string tag, input int qid, input int usedw, input logic last);
    check_value({tag, "_wr"},    64'(o_queue_id_wr),    64'd1);
    check_value({tag, "_qid"},   64'(ov_queue_id),      64'(qid));
    check_value({tag, "_usedw"}, 64'(ov_queue_usedw),   64'(usedw));
    check_value({tag, "_last"},  64'(o_last_frag),      64'(last));
    check_value({tag, "_err"},   64'(o_frag_err),       64'd0);
    check_value({tag, "_full"},  64'(o_all_queue_used), 64'd0);
  endtask

  task automatic expect_err(input string tag);
    check_value({tag, "_wr"},   64'(o_queue_id_wr),    64'd0);
    check_value({tag, "_err"},  64'(o_frag_err),       64'd1);
    check_value({tag, "_full"}, 64'(o_all_queue_used), 64'd0);
  endtask

  initial begin
    i_rst              = 1'b1;
    iv_flowid          = '0;
    iv_frag_id         = '0;
    i_last_frag_flag   = 1'b0;
    i_flowid_wr        = 1'b0;
    iv_queue_id_free   = '0;
    i_queue_id_free_wr = 1'b0;
    repeat (3) cycle();
    check_value("rst_empty", 64'(ov_queue_empty), 64'hFFFF_FFFF);
    check_value("rst_wr",    64'(o_queue_id_wr),   64'd0);
    check_value("rst_qid",   64'(ov_queue_id),     64'd0);
    check_value("rst_usedw", 64'(ov_queue_usedw),  64'd0);
    check_value("rst_tvec",  64'(ov_timeout_vec),  64'd0);
    i_rst = 1'b0;

    // Three-fragment packet on flow 0x005 lands in queue 0.
    send(14'h005, 4'd0, 1'b0); expect_ok("f5_0", 0, 1, 1'b0);
    send(14'h005, 4'd1, 1'b0); expect_ok("f5_1", 0, 2, 1'b0);
    send(14'h005, 4'd2, 1'b1); expect_ok("f5_2", 0, 3, 1'b1);
    check_value("f5_empty", 64'(ov_queue_empty), 64'hFFFF_FFFE);

    // Out-of-order fragment, orphan fragment, and fragment after completion.
    send(14'h0A0, 4'd0, 1'b0); expect_ok("fa_0", 1, 1, 1'b0);
    send(14'h0A0, 4'd2, 1'b0); expect_err("fa_ooo");
    send(14'h0A0, 4'd1, 1'b0); expect_ok("fa_1", 1, 2, 1'b0);
    send(14'h0B0, 4'd1, 1'b0); expect_err("orphan");
    check_value("orphan_empty", 64'(ov_queue_empty), 64'hFFFF_FFFC);
    send(14'h005, 4'd3, 1'b0); expect_err("post_complete");
    do_free(5'd0);
    do_free(5'd1);
    do_free(5'd9);
    check_value("freed_empty", 64'(ov_queue_empty), 64'hFFFF_FFFF);

    // Idle incomplete entry expires exactly TIMEOUT edges after allocation.
    send(14'h100, 4'd0, 1'b0); expect_ok("to_alloc", 0, 1, 1'b0);
    repeat (TIMEOUT - 1) cycle();
    check_value("to_early_tvec",  64'(ov_timeout_vec), 64'd0);
    check_value("to_early_empty", 64'(ov_queue_empty), 64'hFFFF_FFFE);
    cycle();
    check_value("to_tvec",  64'(ov_timeout_vec), 64'd1);
    check_value("to_empty", 64'(ov_queue_empty), 64'hFFFF_FFFF);
    cycle();
    check_value("to_pulse_end", 64'(ov_timeout_vec), 64'd0);
    send(14'h100, 4'd1, 1'b0); expect_err("to_late_frag");

    // A fragment arriving on the expiry edge wins over the timeout.
    send(14'h110, 4'd0, 1'b0); expect_ok("hv_alloc", 0, 1, 1'b0);
    repeat (TIMEOUT - 1) cycle();
    send(14'h110, 4'd1, 1'b0); expect_ok("hv_hit", 0, 2, 1'b0);
    check_value("hv_tvec",  64'(ov_timeout_vec), 64'd0);
    check_value("hv_empty", 64'(ov_queue_empty), 64'hFFFF_FFFE);
    // A release on the expiry edge clears without reporting a timeout.
    repeat (TIMEOUT - 1) cycle();
    do_free(5'd0);
    check_value("fv_tvec",  64'(ov_timeout_vec), 64'd0);
    check_value("fv_empty", 64'(ov_queue_empty), 64'hFFFF_FFFF);
    cycle();
    check_value("fv_tvec2", 64'(ov_timeout_vec), 64'd0);

    // Release and lookup of the same queue in one cycle: release wins.
    for (int i = 0; i < 4; i++) begin
      send(14'h200 + 14'(i), 4'd0, 1'b0); expect_ok("fr_alloc", i, 1, 1'b0);
    end
    iv_queue_id_free   = 5'd3;
    i_queue_id_free_wr = 1'b1;
    send(14'h203, 4'd1, 1'b0);
    i_queue_id_free_wr = 1'b0;
    expect_err("fr_collide");
    check_value("fr_empty", 64'(ov_queue_empty), 64'hFFFF_FFF8);
    send(14'h204, 4'd0, 1'b0); expect_ok("fr_realloc", 3, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_free(5'(i));
    end
    check_value("fr_cleared", 64'(ov_queue_empty), 64'hFFFF_FFFF);

    // Fill one queue to 2^FRAG_W fragments; a further fragment cannot match.
    for (int i = 0; i < 16; i++) begin
      send(14'h300, 4'(i), 1'b0); expect_ok("fill", 0, i + 1, 1'b0);
    end
    send(14'h300, 4'd15, 1'b0); expect_err("fill_over");
    send(14'h300, 4'd0, 1'b0);  expect_err("fill_zero");
    do_free(5'd0);

    // Exhaust every queue, then recycle queue 7.
    for (int i = 0; i < QNUM; i++) begin
      send(14'h400 + 14'(i), 4'd0, 1'b1); expect_ok("all", i, 1, 1'b1);
    end
    check_value("all_empty", 64'(ov_queue_empty), 64'd0);
    send(14'h500, 4'd0, 1'b0);
    check_value("full_wr",   64'(o_queue_id_wr),    64'd0);
    check_value("full_flag", 64'(o_all_queue_used), 64'd1);
    check_value("full_err",  64'(o_frag_err),       64'd0);
    do_free(5'd7);
    check_value("q7_empty", 64'(ov_queue_empty), 64'h0000_0080);
    send(14'h501, 4'd0, 1'b1); expect_ok("q7_reuse", 7, 1, 1'b1);
    check_value("q7_full_again", 64'(ov_queue_empty), 64'd0);

    // Reset with five queues allocated and a strobe pending.
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(14'h600 + 14'(i), 4'd0, 1'b0); expect_ok("r5_alloc", i, 1, 1'b0);
    end
    check_value("r5_empty", 64'(ov_queue_empty), 64'hFFFF_FFE0);
    i_rst = 1'b1;
    send(14'h605, 4'd0, 1'b0);
    i_rst = 1'b0;
    check_value("rr_empty", 64'(ov_queue_empty),   64'hFFFF_FFFF);
    check_value("rr_wr",    64'(o_queue_id_wr),    64'd0);
    check_value("rr_err",   64'(o_frag_err),       64'd0);
    check_value("rr_full",  64'(o_all_queue_used), 64'd0);
    check_value("rr_qid",   64'(ov_queue_id),      64'd0);
    check_value("rr_usedw", 64'(ov_queue_usedw),   64'd0);
    check_value("rr_tvec",  64'(ov_timeout_vec),   64'd0);
    send(14'h605, 4'd0, 1'b0); expect_ok("rr_first", 0, 1, 1'b0);
    send(14'h600, 4'd1, 1'b0); expect_err("rr_stale");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flow_queue_allocator.md
FLOW_QUEUE_ALLOCATOR -- requirements
Module: flow_queue_allocator

Interface
REQ-001 SHALL have parameter FLOWID_W, default 14, flow identifier width.
REQ-002 SHALL have parameter FRAG_W, default 4, fragment index width.
REQ-003 SHALL have parameter QNUM, default 32, number of reassembly queues (power of 2, 2..64).
REQ-004 SHALL have parameter QID_W, default 5, equal to log2(QNUM).
REQ-005 SHALL have parameter AGE_W, default 16, age counter width.
REQ-006 SHALL have parameter TIMEOUT, default 50000, idle cycles after which an incomplete entry is reclaimed (1..2^AGE_W-1).
REQ-007 SHALL have i_clk, input, 1, sole clock; all logic rising-edge.
REQ-008 SHALL have i_rst, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have iv_flowid, input, FLOWID_W, flow id of the arriving fragment.
REQ-010 SHALL have iv_frag_id, input, FRAG_W, fragment index within the packet.
REQ-011 SHALL have i_last_frag_flag, input, 1, fragment is the last of its packet.
REQ-012 SHALL have i_flowid_wr, input, 1, single-cycle strobe qualifying the three inputs above.
REQ-013 SHALL have ov_queue_id, output, QID_W, queue assigned to the fragment.
REQ-014 SHALL have ov_queue_usedw, output, FRAG_W+1, fragments held in that queue including this one.
REQ-015 SHALL have o_queue_id_wr, output, 1, result strobe.
REQ-016 SHALL have o_last_frag, output, 1, copy of i_last_frag_flag qualified by o_queue_id_wr.
REQ-017 SHALL have o_all_queue_used, output, 1, pulse: new flow refused because no queue is empty.
REQ-018 SHALL have o_frag_err, output, 1, pulse: out-of-order, orphan or post-completion fragment dropped.
REQ-019 SHALL have iv_queue_id_free, input, QID_W, queue to release; i_queue_id_free_wr, input, 1, its strobe.
REQ-020 SHALL have ov_queue_empty, output, QNUM, bit q = 1 when queue q is unallocated.
REQ-021 SHALL have ov_timeout_vec, output, QNUM, one-cycle mask of queues reclaimed by aging.

Function
REQ-022 Table SHALL hold per queue: valid, flowid, usedw (FRAG_W+1), complete, age (AGE_W), in registers; lookup SHALL compare all valid entries in parallel.
REQ-023 Latency SHALL be exactly 1 cycle: strobe in cycle N -> o_queue_id_wr/o_all_queue_used/o_frag_err in N+1; table updated at the same edge.
REQ-024 Hit (valid, flowid equal, not complete) with iv_frag_id == usedw: usedw += 1, age := 0, complete := i_last_frag_flag; output queue id and new usedw.
REQ-025 Hit with iv_frag_id != usedw, or hit on a complete entry: o_frag_err, fragment dropped, entry unchanged.
REQ-026 Miss with iv_frag_id == 0: allocate lowest-index empty queue; valid := 1, flowid stored, usedw := 1, age := 0, complete := i_last_frag_flag; output it.
REQ-027 Miss with iv_frag_id != 0: o_frag_err, no allocation.
REQ-028 Miss, frag_id 0, no empty queue: o_all_queue_used, no o_queue_id_wr.
REQ-029 usedw at 2^FRAG_W and a further non-last fragment: impossible by REQ-025 (frag_id cannot equal it); usedw SHALL never wrap.
REQ-030 Free strobe SHALL clear valid/complete/usedw/age of the named queue next edge; freeing an empty queue is a no-op.
REQ-031 Age of every valid incomplete entry SHALL increment per cycle, saturating; complete entries do not age.
REQ-032 When age reaches TIMEOUT the entry SHALL be cleared and its ov_timeout_vec bit pulsed for one cycle; multiple simultaneous timeouts allowed.
REQ-033 Same-cycle free and lookup matching that queue: free wins; lookup treated as miss and that queue excluded from allocation that cycle.
REQ-034 Same-cycle fragment hit and timeout on that entry: hit wins, age := 0, no timeout.
REQ-035 Same-cycle free and timeout on one queue: cleared once, ov_timeout_vec bit NOT set.
REQ-036 Outputs SHALL be registered; exactly one of o_queue_id_wr, o_all_queue_used, o_frag_err per accepted strobe.

Reset
REQ-037 While i_rst=1: all entries invalid, ov_queue_empty all ones, all strobes/pulses 0, ov_queue_id 0, ov_queue_usedw 0, ov_timeout_vec 0; inputs ignored.
REQ-038 Reset asserted mid-packet SHALL discard all partial state; first cycle after release accepts strobes.

Verification
REQ-039 Flow 0x005 frags 0,1,2(last) -> queue 0, usedw 1,2,3, o_last_frag on third; ov_queue_empty bit0 = 0.
REQ-040 QNUM new flows then one more frag_id 0 -> 33rd gives o_all_queue_used; free queue 7 -> next new flow gets queue 7.
REQ-041 Flow A frag 0 then frag 2 -> o_frag_err, usedw stays 1; frag 1 of unknown flow -> o_frag_err, no allocation.
REQ-042 TIMEOUT=16: frag 0 then idle -> ov_timeout_vec bit 0 pulses 16 cycles later, bit0 of ov_queue_empty returns 1; frag 1 later -> o_frag_err.
REQ-043 Free queue 3 in same cycle as matching frag 1 of its flow -> queue 3 freed, fragment reported as o_frag_err (miss, frag_id != 0).
REQ-044 Assert i_rst with 5 queues allocated -> next cycle ov_queue_empty all ones, outputs 0.
